// File: rtl/n_sumador.sv
// Registered N-bit ripple-carry adder/subtractor with carry, overflow and zero flags.
// Define NSUM_SATURATE_EN to clamp signed overflow instead of wrapping.
module n_sumador #(
  parameter int N = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  input  logic         sub,
  output logic [N-1:0] result,
  output logic         cout,
  output logic         overflow,
  output logic         zero,
  output logic         out_valid
);

  logic [N-1:0] bb;
  logic [N-1:0] sum_c;
  logic [N-1:0] final_c;
  logic         carry;
  logic         carry_msb;
  logic         cout_c;
  logic         ovf_c;

  assign bb = sub ? ~b : b;

  // Full-adder cells chained LSB to MSB; carry_msb captures the carry into the top cell.
  always_comb begin
    carry     = cin;
    carry_msb = 1'b0;
    sum_c     = '0;
    for (int i = 0; i < N; i++) begin
      carry_msb = carry;
      sum_c[i]  = a[i] ^ bb[i] ^ carry;
      carry     = (a[i] & bb[i]) | (carry & (a[i] ^ bb[i]));
    end
    cout_c = carry;
    ovf_c  = carry_msb ^ carry;
  end

`ifdef NSUM_SATURATE_EN
  // Operands with a clear sign bit can only overflow upwards.
  always_comb begin
    final_c = sum_c;
    if (ovf_c) begin
      if (!a[N-1] && !bb[N-1])
        final_c = {1'b0, {(N-1){1'b1}}};
      else
        final_c = {1'b1, {(N-1){1'b0}}};
    end
  end
`else
  assign final_c = sum_c;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      result    <= '0;
      cout      <= 1'b0;
      overflow  <= 1'b0;
      zero      <= 1'b0;
      out_valid <= 1'b0;
    end else if (in_valid) begin
      result    <= final_c;
      cout      <= cout_c;
      overflow  <= ovf_c;
      zero      <= (final_c == '0);
      out_valid <= 1'b1;
    end else begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_n_sumador.sv
// Testbench for n_sumador: directed test-plan steps followed by random traffic,
// checked against an integer-arithmetic reference model.
module tb_n_sumador;

  localparam int N    = 5;
  localparam int FULL = 1 << N;
  localparam int HALF = 1 << (N - 1);

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         cin;
  logic         sub;
  logic [N-1:0] result;
  logic         cout;
  logic         overflow;
  logic         zero;
  logic         out_valid;

  int errors = 0;
  int checks = 0;

  logic [N-1:0] expResult;
  logic         expCout;
  logic         expOverflow;
  logic         expZero;
  logic         expValid;

  n_sumador #(.N(N)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .a(a),
    .b(b),
    .cin(cin),
    .sub(sub),
    .result(result),
    .cout(cout),
    .overflow(overflow),
    .zero(zero),
    .out_valid(out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: operate on plain integers, both unsigned and two's-complement views.
  task automatic updateModel(input logic r, input logic v, input int av, input int bv,
                             input int cv, input logic sv);
    int bbv, total, sa, sb, st, res;
    logic ovf;
    if (!r) begin
      expResult = '0; expCout = 0; expOverflow = 0; expZero = 0; expValid = 0;
    end else if (v) begin
      bbv   = sv ? (FULL - 1 - bv) : bv;
      total = av + bbv + cv;
      sa    = (av >= HALF) ? av - FULL : av;
      sb    = (bbv >= HALF) ? bbv - FULL : bbv;
      st    = sa + sb + cv;
      ovf   = (st > HALF - 1) || (st < -HALF);
      res   = total % FULL;
`ifdef NSUM_SATURATE_EN
      if (st > HALF - 1) res = HALF - 1;
      else if (st < -HALF) res = HALF;
`endif
      expResult   = res[N-1:0];
      expCout     = (total >= FULL);
      expOverflow = ovf;
      expZero     = (res == 0);
      expValid    = 1'b1;
    end else begin
      expValid = 1'b0;
    end
  endtask

  task automatic applyStimulus(input logic r, input logic v, input int av, input int bv,
                               input int cv, input logic sv);
    @(negedge clk);
    rst_n    = r;
    in_valid = v;
    a        = av[N-1:0];
    b        = bv[N-1:0];
    cin      = cv[0];
    sub      = sv;
    updateModel(r, v, av, bv, cv, sv);
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag);
    checks++;
    assert (result === expResult) else begin
      errors++;
      $error("[TB] FAIL %s result: got %0d expected %0d", tag, result, expResult);
    end
    checks++;
    assert (cout === expCout) else begin
      errors++;
      $error("[TB] FAIL %s cout: got %b expected %b", tag, cout, expCout);
    end
    checks++;
    assert (overflow === expOverflow) else begin
      errors++;
      $error("[TB] FAIL %s overflow: got %b expected %b", tag, overflow, expOverflow);
    end
    checks++;
    assert (zero === expZero) else begin
      errors++;
      $error("[TB] FAIL %s zero: got %b expected %b", tag, zero, expZero);
    end
    checks++;
    assert (out_valid === expValid) else begin
      errors++;
      $error("[TB] FAIL %s out_valid: got %b expected %b", tag, out_valid, expValid);
    end
  endtask

  task automatic checkConst(input string tag, input logic [N-1:0] want);
    checks++;
    assert (result === want) else begin
      errors++;
      $error("[TB] FAIL %s: got %0d expected %0d", tag, result, want);
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;

    applyStimulus(0, 1, 3, 4, 0, 0);  checkOutput("reset0");
    applyStimulus(0, 1, 3, 4, 0, 0);  checkOutput("reset1");
    applyStimulus(1, 1, 3, 4, 0, 0);  checkOutput("first_add");
    checkConst("first_add_const", 5'd7);

    applyStimulus(1, 1, 1, 0, 1, 0);  checkOutput("cin1");
    checkConst("cin1_const", 5'd2);
    applyStimulus(1, 1, 1, 0, 0, 0);  checkOutput("cin0");
    applyStimulus(1, 1, 31, 1, 0, 0); checkOutput("wrap");
    applyStimulus(1, 1, 5, 7, 1, 1);  checkOutput("sub_borrow");
    checkConst("sub_borrow_const", 5'd30);
    applyStimulus(1, 1, 7, 5, 1, 1);  checkOutput("sub_noborrow");
    applyStimulus(1, 1, 7, 5, 0, 1);  checkOutput("sub_minus1");

    applyStimulus(1, 1, 15, 1, 0, 0); checkOutput("pos_ovf");
`ifdef NSUM_SATURATE_EN
    checkConst("pos_ovf_const", 5'd15);
`else
    checkConst("pos_ovf_const", 5'd16);
`endif
    applyStimulus(1, 1, 16, 31, 0, 0); checkOutput("neg_ovf");
`ifdef NSUM_SATURATE_EN
    checkConst("neg_ovf_const", 5'd16);
`else
    checkConst("neg_ovf_const", 5'd15);
`endif

    applyStimulus(1, 1, 2, 3, 0, 0);  checkOutput("stream0");
    applyStimulus(1, 1, 9, 9, 1, 1);  checkOutput("stream1");
    applyStimulus(1, 1, 20, 6, 1, 0); checkOutput("stream2");
    applyStimulus(1, 0, 1, 1, 0, 0);  checkOutput("hold0");
    applyStimulus(1, 0, 4, 8, 1, 1);  checkOutput("hold1");

    applyStimulus(1, 1, 11, 12, 0, 0); checkOutput("pre_midreset");
    applyStimulus(0, 1, 13, 2, 0, 0);  checkOutput("midreset");

    for (int i = 0; i < 200; i++) begin
      applyStimulus(($urandom_range(0, 19) != 0), ($urandom_range(0, 3) != 0),
                    int'($urandom_range(0, FULL - 1)), int'($urandom_range(0, FULL - 1)),
                    int'($urandom_range(0, 1)), logic'($urandom_range(0, 1)));
      checkOutput("random");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/n_sumador.md
Name: n_sumador

Overview:
- Registered N-bit ripple-carry adder/subtractor with carry-in, carry-out and status flags.
- Generic arithmetic leaf block; instantiated wherever a small pipelined add or subtract is needed.
- Inputs are sampled on the clock edge when valid is asserted.
- Result and flags appear one cycle later with a matching valid strobe.

Parameters:
- N, 5, operand and result width in bits (legal range 2..32).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  synchronous reset, active-low.
- in_valid  input  1  operands valid this cycle.
- a  input  N  operand A.
- b  input  N  operand B.
- cin  input  1  carry-in.
- sub  input  1  0 = add, 1 = subtract (B inverted).
- result  output  N  registered sum/difference.
- cout  output  1  registered carry-out of MSB (for subtract: 1 = no borrow).
- overflow  output  1  registered signed (two's-complement) overflow.
- zero  output  1  registered, 1 when result == 0.
- out_valid  output  1  result/flags updated this cycle.

Behaviour:
- Reset: when rst_n=0 at a rising clk edge, result=0, cout=0, overflow=0, zero=0, out_valid=0. Reset overrides in_valid.
- Datapath is combinational: bb = sub ? ~b : b; {cout_c, sum_c} = a + bb + cin, computed as N chained full-adder cells.
- The full-adder cell is sum = x^y^c, carry = xy | c(x^y).
- Subtraction convention:
  - sub=1, cin=1 gives a-b.
  - sub=1, cin=0 gives a-b-1.
- Signed overflow: ovf_c = carry into MSB XOR carry out of MSB.
- Latency is exactly 1 cycle. On a rising edge with rst_n=1 and in_valid=1:
  - result <= sum_c, cout <= cout_c, overflow <= ovf_c, zero <= (sum_c==0), out_valid <= 1.
- On a rising edge with rst_n=1 and in_valid=0: result, cout, overflow and zero hold their values; out_valid <= 0.
- Throughput is one operation per cycle; back-to-back in_valid produces back-to-back out_valid.
- There is no backpressure.
- Wrap-around: results are modulo 2^N; the carry is visible only on cout.
- Flag consistency: zero is derived from the final result after the optional saturation stage.
- Reset asserted mid-stream drops any pending result: out_valid=0 on the next cycle, with no partial output.
- The design contains no latches and no combinational path from inputs to outputs.

Optional Feature:
- Macro: NSUM_SATURATE_EN.
- Defined: when ovf_c=1, result saturates instead of wrapping.
  - Positive overflow (MSB of a and bb both 0) clamps to 0 followed by N-1 ones (N=5: 01111).
  - Negative overflow clamps to 1 followed by N-1 zeros (N=5: 10000).
  - overflow flag still asserts; cout is unchanged (raw carry).
- Undefined: plain modulo-2^N wrap; saturation logic absent from the netlist.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with in_valid=1, a=3, b=4 -> all outputs 0, out_valid=0. Release; next edge with a=3, b=4, cin=0, sub=0 -> result=7, out_valid=1 one cycle later.
- Carry-in: a=1, b=0, cin=1, sub=0 -> result=2, cout=0, zero=0, overflow=0. Same with cin=0 -> result=1.
- Wrap/carry (N=5): a=31, b=1, cin=0 -> result=0, cout=1, zero=1, overflow=0.
- Subtract: a=5, b=7, sub=1, cin=1 -> result=30 (-2), cout=0 (borrow), overflow=0. With a=7, b=5 -> result=2, cout=1.
- Signed overflow: a=15, b=1, sub=0, cin=0 -> overflow=1.
  - Without NSUM_SATURATE_EN: result=16.
  - With NSUM_SATURATE_EN: result=15.
  - Case a=16, b=31, sub=0 -> overflow=1; result=15 (wrap) or 16 (saturate).
- Hold/stream: drive 3 consecutive valid ops, then in_valid=0 for 2 cycles -> 3 consecutive out_valid pulses with correct results; outputs hold the last result while out_valid=0.
